// File: rtl/result_serializer.sv
// SPI-slave transmit path: buffers one completion record and shifts it out MSB-first
// on miso during the next full host frame; an empty buffer yields an all-zero frame.
module result_serializer #(
   parameter int ADDRW   = 8,
   parameter int OPCODEW = 2,
   parameter int STATUSW = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               spi_clk,
   input  logic               cs_n,
   output logic               miso,
   input  logic               valid_in,
   output logic               ready_out,
   input  logic [OPCODEW-1:0] opcode_in,
   input  logic [ADDRW-1:0]   dest_addr_in,
   input  logic [STATUSW-1:0] status_in,
   output logic               tx_done
);

   localparam int SHIFT_W = 1 + OPCODEW + ADDRW + STATUSW;
   localparam int CNT_W   = $clog2(SHIFT_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SHIFT_W);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state, state_next;
   logic               spi_meta, spi_sync, spi_prev;
   logic               cs_meta, cs_sync, cs_prev;
   logic               spi_rise, spi_fall, cs_fall, cs_rise;
   logic               rec_full;
   logic [SHIFT_W-1:0] rec_buf;
   logic [SHIFT_W-1:0] shreg, shreg_next;
   logic [CNT_W-1:0]   bit_cnt, bit_cnt_next;
   logic               frame_has_data, frame_has_data_next;
   logic               deliver;

   // cs_n synchroniser resets high so leaving reset never fakes a frame start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spi_meta <= 1'b0;
         spi_sync <= 1'b0;
         spi_prev <= 1'b0;
         cs_meta  <= 1'b1;
         cs_sync  <= 1'b1;
         cs_prev  <= 1'b1;
      end else begin
         spi_meta <= spi_clk;
         spi_sync <= spi_meta;
         spi_prev <= spi_sync;
         cs_meta  <= cs_n;
         cs_sync  <= cs_meta;
         cs_prev  <= cs_sync;
      end
   end

   assign spi_rise  = spi_sync & ~spi_prev;
   assign spi_fall  = ~spi_sync & spi_prev;
   assign cs_fall   = ~cs_sync & cs_prev;
   assign cs_rise   = cs_sync & ~cs_prev;
   assign ready_out = ~rec_full;
   assign miso      = (state == SHIFT) & shreg[SHIFT_W-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rec_full <= 1'b0;
         rec_buf  <= '0;
      end else if (deliver) begin
         rec_full <= 1'b0;
      end else if (valid_in && !rec_full) begin
         rec_full <= 1'b1;
         rec_buf  <= {1'b1, opcode_in, dest_addr_in, status_in};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         shreg          <= '0;
         bit_cnt        <= '0;
         frame_has_data <= 1'b0;
         tx_done        <= 1'b0;
      end else begin
         state          <= state_next;
         shreg          <= shreg_next;
         bit_cnt        <= bit_cnt_next;
         frame_has_data <= frame_has_data_next;
         tx_done        <= deliver;
      end
   end

   // A frame only counts as delivered if the host clocked every bit before deselecting
   always_comb begin
      state_next          = state;
      shreg_next          = shreg;
      bit_cnt_next        = bit_cnt;
      frame_has_data_next = frame_has_data;
      deliver             = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               state_next          = SHIFT;
               shreg_next          = rec_full ? rec_buf : '0;
               frame_has_data_next = rec_full;
               bit_cnt_next        = '0;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               state_next = IDLE;
               deliver    = (bit_cnt == CNT_MAX) && frame_has_data;
            end else begin
               if (spi_rise && (bit_cnt != CNT_MAX)) begin
                  bit_cnt_next = bit_cnt + CNT_W'(1);
               end
               if (spi_fall) begin
                  shreg_next = {shreg[SHIFT_W-2:0], 1'b0};
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: a behavioural host plus a one-entry buffer model
// predicts every frame's bits, tx_done pulse count and ready_out.
module tb_result_serializer;

   localparam int SHIFT_W = 15;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       spi_clk;
   logic       cs_n;
   logic       miso;
   logic       valid_in;
   logic       ready_out;
   logic [1:0] opcode_in;
   logic [7:0] dest_addr_in;
   logic [3:0] status_in;
   logic       tx_done;

   int vec_cnt = 0;
   int err_cnt = 0;
   int done_cnt = 0;

   logic               model_full;
   logic [SHIFT_W-1:0] model_rec;

   result_serializer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .spi_clk      (spi_clk),
      .cs_n         (cs_n),
      .miso         (miso),
      .valid_in     (valid_in),
      .ready_out    (ready_out),
      .opcode_in    (opcode_in),
      .dest_addr_in (dest_addr_in),
      .status_in    (status_in),
      .tx_done      (tx_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_done === 1'b1) done_cnt++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Offers one record for a single cycle; the model accepts it only when empty
   task automatic applyStimulus(input logic [13:0] rec);
      @(negedge clk);
      checkOutput("ready_before_load", {31'd0, ready_out}, {31'd0, ~model_full});
      valid_in     = 1'b1;
      opcode_in    = rec[13:12];
      dest_addr_in = rec[11:4];
      status_in    = rec[3:0];
      @(negedge clk);
      valid_in = 1'b0;
      if (!model_full) begin
         model_full = 1'b1;
         model_rec  = {1'b1, rec};
      end
   endtask

   // Host side: 60 ns select setup, 30 ns half-periods, bit read while spi_clk is high
   task automatic host_frame(input int nbits, input int load_at, input logic [13:0] load_rec,
                             output logic [31:0] got);
      got  = '0;
      cs_n = 1'b0;
      #60;
      for (int i = 0; i < nbits; i++) begin
         if (i == load_at) applyStimulus(load_rec);
         spi_clk = 1'b1;
         #29;
         got = {got[30:0], miso};
         #1;
         spi_clk = 1'b0;
         #30;
      end
      cs_n = 1'b1;
      #80;
   endtask

   task automatic do_frame(input string tag, input int nbits, input int load_at, input logic [13:0] load_rec);
      logic               cap_full;
      logic [SHIFT_W-1:0] cap;
      logic [31:0]        got;
      logic [31:0]        exp;
      int                 d0;
      cap_full = model_full;
      cap      = model_full ? model_rec : '0;
      exp      = '0;
      for (int i = 0; i < nbits; i++) begin
         exp = {exp[30:0], (i < SHIFT_W) ? cap[SHIFT_W-1-i] : 1'b0};
      end
      d0 = done_cnt;
      host_frame(nbits, load_at, load_rec, got);
      checkOutput({tag, "_data"}, got, exp);
      if (cap_full && nbits >= SHIFT_W) begin
         model_full = 1'b0;
         if (valid_in) begin
            model_full = 1'b1;
            model_rec  = {1'b1, opcode_in, dest_addr_in, status_in};
         end
      end
      checkOutput({tag, "_done"}, 32'(done_cnt - d0), (cap_full && nbits >= SHIFT_W) ? 32'd1 : 32'd0);
      checkOutput({tag, "_ready"}, {31'd0, ready_out}, {31'd0, ~model_full});
   endtask

   initial begin
      logic [13:0] r;
      int          nb;
      rst_n        = 1'b0;
      spi_clk      = 1'b0;
      cs_n         = 1'b1;
      valid_in     = 1'b0;
      opcode_in    = '0;
      dest_addr_in = '0;
      status_in    = '0;
      model_full   = 1'b0;
      model_rec    = '0;
      #12;
      checkOutput("rst_miso", {31'd0, miso}, 32'd0);
      checkOutput("rst_ready", {31'd0, ready_out}, 32'd1);
      checkOutput("rst_tx_done", {31'd0, tx_done}, 32'd0);
      #11 rst_n = 1'b1;
      #40;

      applyStimulus({2'b01, 8'h0E, 4'h3});
      do_frame("basic", 15, -1, '0);
      do_frame("empty", 15, -1, '0);

      applyStimulus({2'b10, 8'h7C, 4'h0});
      do_frame("abort7", 7, -1, '0);
      do_frame("retry", 15, -1, '0);

      applyStimulus({2'b01, 8'hA5, 4'h9});
      @(negedge clk);
      valid_in     = 1'b1;
      opcode_in    = 2'b11;
      dest_addr_in = 8'h3C;
      status_in    = 4'h5;
      @(negedge clk);
      checkOutput("hold_ready", {31'd0, ready_out}, 32'd0);
      do_frame("hold_first", 15, -1, '0);
      valid_in = 1'b0;
      do_frame("hold_second", 15, -1, '0);

      do_frame("load_mid", 15, 4, {2'b11, 8'h12, 4'hA});
      do_frame("long20", 20, -1, '0);

      applyStimulus({2'b11, 8'hFF, 4'hF});
      cs_n = 1'b0;
      #60;
      for (int i = 0; i < 5; i++) begin
         spi_clk = 1'b1;
         #30;
         spi_clk = 1'b0;
         #30;
      end
      spi_clk = 1'b1;
      #10;
      rst_n = 1'b0;
      #10;
      checkOutput("midrst_miso", {31'd0, miso}, 32'd0);
      checkOutput("midrst_ready", {31'd0, ready_out}, 32'd1);
      checkOutput("midrst_tx_done", {31'd0, tx_done}, 32'd0);
      spi_clk    = 1'b0;
      cs_n       = 1'b1;
      model_full = 1'b0;
      #20 rst_n = 1'b1;
      #40;
      do_frame("post_rst", 15, -1, '0);

      for (int k = 0; k < 40; k++) begin
         r  = 14'($urandom);
         nb = $urandom_range(20, 1);
         if ($urandom_range(1, 0) == 1) applyStimulus(r);
         if ($urandom_range(3, 0) == 0 && nb > 3)
            do_frame("rand_midload", nb, 2, 14'($urandom));
         else
            do_frame("rand", nb, -1, '0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
